fpnew_fma_special_prep: RTL and testbench
=========================================

// Module: fpnew_fma_special_prep
// PURPOSE
//  Upstream stage of the FP32 FMA special-case path (computes a*b+c).
//  - Classifies operands a, b and c: zero, infinity, quiet NaN or signalling NaN.
//  - Derives the special-case controls that the FMA special-result mux consumes (use_sign, sign).
//  - Derives the invalid-operation flag.
//  - Carries all of this through an elastic valid/ready pipeline, with a tag field and flush.
// PARAMETERS
//  NumPipeRegs  1  number of register stages; 0 = combinational pass-through
//  TagWidth     4  width of the opaque tag carried alongside each operation
// PORTS
//  clk_i            in   1         clock; all state updates on its rising edge
//  rst_i            in   1         asynchronous reset, active-high
//  flush_i          in   1         synchronous kill of all in-flight operations
//  in_valid_i       in   1         operand triple is valid
//  in_ready_o       out  1         stage can accept the operand triple
//  operands_i       in   96        {c[95:64], b[63:32], a[31:0]}, IEEE binary32 each
//  tag_i            in   TagWidth  opaque tag
//  out_valid_o      out  1         result controls are valid
//  out_ready_i      in   1         downstream accepts the result controls
//  special_case_o   out  1         result is a special value; downstream bypasses the datapath
//  use_sign_o       out  1         1 = signed infinity {sign_o,8'hFF,23'h0}; 0 = canonical NaN 32'h7FC00000
//  sign_o           out  1         sign of the infinity; 0 when use_sign_o=0
//  nv_o             out  1         IEEE invalid-operation flag
//  tag_o            out  TagWidth  tag of the operation at the output
//  busy_o           out  1         OR of all stage valid bits
// BEHAVIOUR
//  Classification per operand, on exponent e and mantissa m:
//    zero = (e==0 && m==0); inf = (e==8'hFF && m==0); nan = (e==8'hFF && m!=0); snan = nan && !m[22].
//    Subnormals are not special and need no handling here.
//  Control decode; the first matching rule in this order wins:
//    1. Any NaN operand, or inf*0 (either order), or (a|b inf) && c inf && sign(a)^sign(b)!=sign(c):
//       special=1, use_sign=0, sign=0.
//       nv=1 if any operand is sNaN, for inf*0, or for the inf-minus-inf case.
//       nv=0 if the only special operands are qNaNs.
//    2. a or b inf (product inf, other factor nonzero): special=1, use_sign=1, sign=sa^sb, nv=0.
//    3. c inf only: special=1, use_sign=1, sign=sc, nv=0.
//    4. Otherwise: special=0, use_sign=0, sign=0, nv=0.
//  Decode is combinational at stage 0; the result is registered NumPipeRegs times.
//  Latency is NumPipeRegs cycles when no stalls occur.
//  Handshake:
//    - Transfer occurs when valid && ready on a cycle.
//    - Each stage register is ready = next_ready || !valid_q, so bubbles collapse.
//    - in_ready_o is the ready of stage 0.
//    - Stage data loads only on transfer. Data of a stalled stage holds stable.
//    - out_valid_o never drops without a transfer.
//    - Back-to-back throughput is 1 operation per cycle.
//  Flush: when flush_i=1, all valid bits clear on the next edge.
//    - An input presented in the same cycle is dropped.
//    - in_ready_o is unaffected.
//  Reset (rst_i=1, asynchronous): all valid bits=0 and all data registers=0.
//    - Hence out_valid_o=0, special_case_o=0, use_sign_o=0, sign_o=0, nv_o=0, tag_o=0, busy_o=0.
//    - in_ready_o=1 while in reset.
//    - Reset asserted mid-operation discards in-flight work with no output transfer.
//  Simultaneous input and output transfer at a full stage: the stage holds the new data and stays valid.
//  NumPipeRegs=0: outputs are a combinational function of the inputs.
//    - out_valid_o=in_valid_i and in_ready_o=out_ready_i.
//    - flush_i has no effect.
// STRUCTURE
//  Shared package fpnew_pkg holds:
//    - fp_info_t, a struct {is_zero, is_inf, is_nan, is_snan}.
//    - fma_spec_t, a struct {special, use_sign, sign, nv}.
//    - FP32 constants EXP_BITS=8, MAN_BITS=23, QNAN_BIT=22.
//  Sub-module fpnew_classifier: 32-bit operand -> fp_info_t, combinational, instantiated 3x.
//  Pipeline: generate loop over NumPipeRegs stages, each holding {fma_spec_t, tag, valid}.
// TESTING
//  1. Reset, then a=3F800000, b=7F800000, c=40000000, tag=5, NumPipeRegs=1
//     -> next cycle: special=1, use_sign=1, sign=0, nv=0, tag_o=5.
//  2. a=FF800000, b=00000000, c=3F800000 -> special=1, use_sign=0, nv=1. Swap a and b -> same result.
//  3. a=7F800000, b=3F800000, c=FF800000 -> nv=1, NaN.
//     c=7F800000 instead -> use_sign=1, sign=0, nv=0.
//  4. a=7FA00000 (sNaN) -> nv=1. a=7FC00000 (qNaN) -> nv=0. Both give use_sign=0.
//     a=3F800000, b=3F800000, c=BF800000 -> special=0.
//  5. Stream 8 ops while out_ready_i toggles randomly -> every op appears once, in order, tags intact,
//     data stable while stalled. Full throughput when out_ready_i is held at 1.
//  6. Two ops in flight, then flush_i=1 for one cycle -> busy_o=0 next cycle with no output transfer.
//     Assert rst_i mid-stream -> outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpnew_pkg.sv
// FP32 classification/special-case types and the FMA special-case decode.
// Everything in here is shared by the classifier and the special-case prep stage.
package fpnew_pkg;

  localparam int EXP_BITS = 8;
  localparam int MAN_BITS = 23;
  localparam int QNAN_BIT = 22;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
    logic is_snan;
  } fp_info_t;

  typedef struct packed {
    logic special;
    logic use_sign;
    logic sign;
    logic nv;
  } fma_spec_t;

  // Priority: NaN-producing cases first, then product infinity, then addend infinity.
  function automatic fma_spec_t fma_decode(input fp_info_t ia, input fp_info_t ib,
                                           input fp_info_t ic, input logic sa,
                                           input logic sb, input logic sc);
    fma_spec_t r;
    logic any_nan, any_snan, inf_zero, prod_inf, prod_sign, inf_sub;
    r         = '0;
    any_nan   = ia.is_nan | ib.is_nan | ic.is_nan;
    any_snan  = ia.is_snan | ib.is_snan | ic.is_snan;
    inf_zero  = (ia.is_inf & ib.is_zero) | (ib.is_inf & ia.is_zero);
    prod_inf  = ia.is_inf | ib.is_inf;
    prod_sign = sa ^ sb;
    inf_sub   = prod_inf & ic.is_inf & (prod_sign != sc);
    if (any_nan || inf_zero || inf_sub) begin
      r.special = 1'b1;
      r.nv      = any_snan | inf_zero | inf_sub;
    end else if (prod_inf) begin
      r.special  = 1'b1;
      r.use_sign = 1'b1;
      r.sign     = prod_sign;
    end else if (ic.is_inf) begin
      r.special  = 1'b1;
      r.use_sign = 1'b1;
      r.sign     = sc;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpnew_fma_special_prep_if.sv
// Operand/result handshake bundle of the FMA special-case prep stage.
// master = producer of operands and consumer of results; slave = the prep stage.
interface fpnew_fma_special_prep_if #(
  parameter int TagWidth = 4
);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [95:0]         operands_i;
  logic [TagWidth-1:0] tag_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic                special_case_o;
  logic                use_sign_o;
  logic                sign_o;
  logic                nv_o;
  logic [TagWidth-1:0] tag_o;

  modport master (
    output in_valid_i, operands_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, special_case_o, use_sign_o, sign_o, nv_o, tag_o
  );

  modport slave (
    input  in_valid_i, operands_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, special_case_o, use_sign_o, sign_o, nv_o, tag_o
  );
endinterface

// File: rtl/fpnew_classifier.sv
// Classifies one binary32 operand as zero / infinity / NaN / signalling NaN.
// Purely combinational; subnormals classify as ordinary numbers.
module fpnew_classifier
  import fpnew_pkg::*;
(
  input  logic [31:0] operand,
  output fp_info_t    info
);

  logic [EXP_BITS-1:0] exp_f;
  logic [MAN_BITS-1:0] man_f;

  assign exp_f = operand[EXP_BITS+MAN_BITS-1:MAN_BITS];
  assign man_f = operand[MAN_BITS-1:0];

  always_comb begin
    info         = '0;
    info.is_zero = (exp_f == '0) && (man_f == '0);
    info.is_inf  = (exp_f == '1) && (man_f == '0);
    info.is_nan  = (exp_f == '1) && (man_f != '0);
    info.is_snan = info.is_nan && !man_f[QNAN_BIT];
  end

endmodule

// File: rtl/fpnew_fma_special_prep.sv
// FMA special-case prep: classify a,b,c and decode special/use_sign/sign/nv, tag carried along.
// Latency NumPipeRegs cycles; each stage ready = next_ready || !valid, flush clears all valids.
module fpnew_fma_special_prep
  import fpnew_pkg::*;
#(
  parameter int NumPipeRegs = 1,
  parameter int TagWidth    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  output logic                     busy_o,
  fpnew_fma_special_prep_if.slave  io
);

  fp_info_t  info [3];
  fma_spec_t spec_d;
  fma_spec_t out_spec;

  for (genvar g = 0; g < 3; g++) begin : g_cls
    fpnew_classifier u_cls (
      .operand (io.operands_i[32*g +: 32]),
      .info    (info[g])
    );
  end

  assign spec_d = fma_decode(info[0], info[1], info[2],
                             io.operands_i[31], io.operands_i[63], io.operands_i[95]);

  if (NumPipeRegs == 0) begin : g_comb
    assign io.out_valid_o = io.in_valid_i;
    assign io.in_ready_o  = io.out_ready_i;
    assign out_spec       = spec_d;
    assign io.tag_o       = io.tag_i;
    assign busy_o         = 1'b0;
  end else begin : g_pipe
    // Index 0 of each chain is the stage-0 input; index i+1 is the output of stage i.
    fma_spec_t           spec_c [NumPipeRegs+1];
    logic [TagWidth-1:0] tag_c  [NumPipeRegs+1];
    logic [NumPipeRegs:0] vld_c;
    logic [NumPipeRegs:0] rdy;

    assign spec_c[0]        = spec_d;
    assign tag_c[0]         = io.tag_i;
    assign vld_c[0]         = io.in_valid_i;
    assign rdy[NumPipeRegs] = io.out_ready_i;

    for (genvar i = 0; i < NumPipeRegs; i++) begin : g_stage
      fma_spec_t           spec_q;
      logic [TagWidth-1:0] tag_q;
      logic                vld_q;

      assign rdy[i]      = rdy[i+1] | ~vld_q;
      assign spec_c[i+1] = spec_q;
      assign tag_c[i+1]  = tag_q;
      assign vld_c[i+1]  = vld_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vld_q  <= 1'b0;
          spec_q <= '0;
          tag_q  <= '0;
        end else begin
          if (flush_i) begin
            vld_q <= 1'b0;
          end else if (rdy[i]) begin
            vld_q <= vld_c[i];
          end
          if (vld_c[i] && rdy[i] && !flush_i) begin
            spec_q <= spec_c[i];
            tag_q  <= tag_c[i];
          end
        end
      end
    end

    assign io.in_ready_o  = rdy[0];
    assign io.out_valid_o = vld_c[NumPipeRegs];
    assign out_spec       = spec_c[NumPipeRegs];
    assign io.tag_o       = tag_c[NumPipeRegs];
    assign busy_o         = |vld_c[NumPipeRegs:1];
  end

  assign io.special_case_o = out_spec.special;
  assign io.use_sign_o     = out_spec.use_sign;
  assign io.sign_o         = out_spec.sign;
  assign io.nv_o           = out_spec.nv;

endmodule

// File: tb/tb_fpnew_fma_special_prep.sv
// Directed bench for the FMA special-case prep stage with one register stage.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_fpnew_fma_special_prep;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  fpnew_fma_special_prep_if #(.TagWidth(4)) bus ();

  fpnew_fma_special_prep #(.NumPipeRegs(1), .TagWidth(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .busy_o  (busy),
    .io      (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] flags();
    return {bus.special_case_o, bus.use_sign_o, bus.sign_o, bus.nv_o};
  endfunction

  task automatic apply_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [3:0] tag);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.operands_i  = {c, b, a};
    bus.tag_i       = tag;
    @(negedge clk);
    bus.in_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    #2;
    obs = {bus.out_valid_o, flags(), bus.tag_o, busy};
    total++;
    if (obs !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b", obs, 10'b0);
    end
    total++;
    if (bus.in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    apply_op(32'h3F800000, 32'h7F800000, 32'h40000000, 4'h5);
    total++;
    if ({bus.out_valid_o, flags(), bus.tag_o} !== 9'b1_1100_0101) begin
      bad++;
      $display("FAIL basic_inf_product: got %b want %b", {bus.out_valid_o, flags(), bus.tag_o}, 9'b1_1100_0101);
    end
  endtask

  task automatic test_inf_zero();
    apply_op(32'hFF800000, 32'h00000000, 32'h3F800000, 4'h1);
    total++;
    if ({bus.out_valid_o, flags(), bus.tag_o} !== 9'b1_1001_0001) begin
      bad++;
      $display("FAIL inf_times_zero: got %b want %b", {bus.out_valid_o, flags(), bus.tag_o}, 9'b1_1001_0001);
    end
    apply_op(32'h00000000, 32'hFF800000, 32'h3F800000, 4'h2);
    total++;
    if ({bus.out_valid_o, flags(), bus.tag_o} !== 9'b1_1001_0010) begin
      bad++;
      $display("FAIL zero_times_inf: got %b want %b", {bus.out_valid_o, flags(), bus.tag_o}, 9'b1_1001_0010);
    end
    apply_op(32'h7F800000, 32'h80000000, 32'h7FC00000, 4'h3);
    total++;
    if ({bus.out_valid_o, flags(), bus.tag_o} !== 9'b1_1001_0011) begin
      bad++;
      $display("FAIL inf_zero_qnan_c: got %b want %b", {bus.out_valid_o, flags(), bus.tag_o}, 9'b1_1001_0011);
    end
  endtask

  task automatic test_inf_sub();
    apply_op(32'h7F800000, 32'h3F800000, 32'hFF800000, 4'h4);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_1001) begin
      bad++;
      $display("FAIL inf_minus_inf: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_1001);
    end
    apply_op(32'h7F800000, 32'h3F800000, 32'h7F800000, 4'h6);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_1100) begin
      bad++;
      $display("FAIL inf_plus_inf: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_1100);
    end
    apply_op(32'h7F800000, 32'hBF800000, 32'h7F800000, 4'h7);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_1001) begin
      bad++;
      $display("FAIL neg_prod_inf_minus_inf: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_1001);
    end
    apply_op(32'h7F800000, 32'hBF800000, 32'h3F800000, 4'h8);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_1110) begin
      bad++;
      $display("FAIL neg_prod_inf: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_1110);
    end
    apply_op(32'h3F800000, 32'h3F800000, 32'hFF800000, 4'h9);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_1110) begin
      bad++;
      $display("FAIL c_neg_inf_only: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_1110);
    end
    // A subnormal factor is nonzero, so inf * subnormal is a plain signed infinity.
    apply_op(32'h00000001, 32'hFF800000, 32'h40000000, 4'hA);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_1110) begin
      bad++;
      $display("FAIL subnormal_times_inf: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_1110);
    end
  endtask

  task automatic test_nan();
    apply_op(32'h7FA00000, 32'h3F800000, 32'h3F800000, 4'hB);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_1001) begin
      bad++;
      $display("FAIL snan_a: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_1001);
    end
    apply_op(32'h7FC00000, 32'h3F800000, 32'h3F800000, 4'hC);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_1000) begin
      bad++;
      $display("FAIL qnan_a: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_1000);
    end
    apply_op(32'h3F800000, 32'h3F800000, 32'hBF800000, 4'hD);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_0000) begin
      bad++;
      $display("FAIL normal_operands: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_0000);
    end
    apply_op(32'h3F800000, 32'hFFC00000, 32'h7F800001, 4'hE);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_1001) begin
      bad++;
      $display("FAIL snan_c_qnan_b: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_1001);
    end
    apply_op(32'h00000000, 32'h00000000, 32'h80000000, 4'hF);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_0000) begin
      bad++;
      $display("FAIL all_zeros: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_0000);
    end
    apply_op(32'hFF800000, 32'h7FC00000, 32'h3F800000, 4'h0);
    total++;
    if ({bus.out_valid_o, flags()} !== 5'b1_1000) begin
      bad++;
      $display("FAIL qnan_with_inf: got %b want %b", {bus.out_valid_o, flags()}, 5'b1_1000);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ca [4];
    logic [31:0] cb [4];
    logic [31:0] cc [4];
    logic [3:0]  ef [4];
    logic [8:0]  held;
    logic        held_vld;
    int sent;
    int recv;
    ca[0] = 32'h3F800000; cb[0] = 32'h3F800000; cc[0] = 32'h3F800000; ef[0] = 4'b0000;
    ca[1] = 32'h7F800000; cb[1] = 32'h40000000; cc[1] = 32'h3F800000; ef[1] = 4'b1100;
    ca[2] = 32'h7F800001; cb[2] = 32'h3F800000; cc[2] = 32'h00000000; ef[2] = 4'b1001;
    ca[3] = 32'h3F800000; cb[3] = 32'h3F800000; cc[3] = 32'hFF800000; ef[3] = 4'b1110;
    sent = 0;
    recv = 0;
    held = '0;
    held_vld = 1'b0;
    for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
      @(negedge clk);
      if (held_vld) begin
        total++;
        if ({bus.out_valid_o, flags(), bus.tag_o} !== held) begin
          bad++;
          $display("FAIL stream_stall_hold: got %b want %b", {bus.out_valid_o, flags(), bus.tag_o}, held);
        end
      end
      bus.out_ready_i = 1'($urandom_range(0, 1));
      if (sent < 8) begin
        bus.in_valid_i = 1'b1;
        bus.operands_i = {cc[sent%4], cb[sent%4], ca[sent%4]};
        bus.tag_i      = 4'(sent);
      end else begin
        bus.in_valid_i = 1'b0;
      end
      #1;
      if (bus.out_valid_o && bus.out_ready_i) begin
        total++;
        if ({flags(), bus.tag_o} !== {ef[recv%4], 4'(recv)}) begin
          bad++;
          $display("FAIL stream_order: got %b want %b", {flags(), bus.tag_o}, {ef[recv%4], 4'(recv)});
        end
        recv++;
      end
      held_vld = bus.out_valid_o && !bus.out_ready_i;
      held     = {bus.out_valid_o, flags(), bus.tag_o};
      if (bus.in_valid_i && bus.in_ready_o) sent++;
    end
    bus.in_valid_i = 1'b0;
    total++;
    if (recv != 8) begin
      bad++;
      $display("FAIL stream_count: got %0d want 8", recv);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.out_ready_i = 1'b1;
      if (i < 8) begin
        bus.in_valid_i = 1'b1;
        bus.operands_i = {32'h3F800000, 32'h3F800000, 32'h7F800000};
        bus.tag_i      = 4'(i + 8);
      end else begin
        bus.in_valid_i = 1'b0;
      end
      #1;
      if (i > 0) begin
        total++;
        if ({bus.out_valid_o, bus.tag_o} !== {1'b1, 4'(i + 7)}) begin
          bad++;
          $display("FAIL b2b_output: got %b want %b", {bus.out_valid_o, bus.tag_o}, {1'b1, 4'(i + 7)});
        end
      end
      if (i < 8) begin
        total++;
        if (bus.in_ready_o !== 1'b1) begin
          bad++;
          $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready_o);
        end
      end
    end
    @(negedge clk);
    total++;
    if ({bus.out_valid_o, busy} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_drain: got %b want 00", {bus.out_valid_o, busy});
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.operands_i  = {32'h3F800000, 32'h40000000, 32'h7F800000};
    bus.tag_i       = 4'h3;
    @(negedge clk);
    total++;
    if ({bus.out_valid_o, busy} !== 2'b11) begin
      bad++;
      $display("FAIL flush_preload: got %b want 11", {bus.out_valid_o, busy});
    end
    bus.operands_i = {32'h3F800000, 32'h3F800000, 32'h3F800000};
    bus.tag_i      = 4'h4;
    flush          = 1'b1;
    #1;
    total++;
    if (bus.in_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_in_ready_full: got %b want 0", bus.in_ready_o);
    end
    @(negedge clk);
    flush          = 1'b0;
    bus.in_valid_i = 1'b0;
    total++;
    if ({bus.out_valid_o, busy} !== 2'b00) begin
      bad++;
      $display("FAIL flush_clears: got %b want 00", {bus.out_valid_o, busy});
    end
    // Empty stage: flush leaves in_ready high but still drops the presented input.
    @(negedge clk);
    flush          = 1'b1;
    bus.in_valid_i = 1'b1;
    #1;
    total++;
    if (bus.in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL flush_in_ready_empty: got %b want 1", bus.in_ready_o);
    end
    @(negedge clk);
    flush          = 1'b0;
    bus.in_valid_i = 1'b0;
    total++;
    if ({bus.out_valid_o, busy} !== 2'b00) begin
      bad++;
      $display("FAIL flush_drops_input: got %b want 00", {bus.out_valid_o, busy});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.operands_i  = {32'hFF800000, 32'h3F800000, 32'h3F800000};
    bus.tag_i       = 4'h9;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    total++;
    if ({bus.out_valid_o, flags(), bus.tag_o} !== 9'b1_1110_1001) begin
      bad++;
      $display("FAIL midrst_preload: got %b want %b", {bus.out_valid_o, flags(), bus.tag_o}, 9'b1_1110_1001);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.out_valid_o, flags(), bus.tag_o, busy} !== 10'b0) begin
      bad++;
      $display("FAIL midrst_async_clear: got %b want %b", {bus.out_valid_o, flags(), bus.tag_o, busy}, 10'b0);
    end
    total++;
    if (bus.in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.out_valid_o, busy} !== 2'b00) begin
      bad++;
      $display("FAIL midrst_after_release: got %b want 00", {bus.out_valid_o, busy});
    end
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.operands_i  = '0;
    bus.tag_i       = '0;
    test_reset();
    test_basic();
    test_inf_zero();
    test_inf_sub();
    test_nan();
    test_stream();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
